// File: rtl/mc_port_alloc_seq.sv
// Sequential multicast port allocator: walks one priority-sorted flit slot per
// cycle, granting productive free ports while capping multicast replicas.
module mc_port_alloc_seq #(
  parameter int NUM_IN        = 4,
  parameter int NUM_OUT       = 4,
  parameter int CNT_W         = 3,
  parameter int REPLICA_LIMIT = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_IN-1:0]         in_valid,
  input  logic [NUM_IN-1:0]         in_mc,
  input  logic [NUM_IN*NUM_OUT-1:0] in_ppv,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_IN*NUM_OUT-1:0] alloc_vec,
  output logic [NUM_IN*NUM_OUT-1:0] unalloc_vec,
  output logic [NUM_OUT-1:0]        avail_out,
  output logic [CNT_W-1:0]          num_flit_out
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [CNT_W:0] LIM = (CNT_W+1)'(REPLICA_LIMIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

  typedef enum logic [1:0] {S_IDLE, S_ALLOC, S_DONE} state_e;

  // Handshake: start is a level sampled only in S_IDLE; done is a one-cycle
  // pulse and the result outputs stay stable from done until the next accepted start.

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [NUM_IN-1:0]         mc_q, mc_d;
  logic [NUM_IN*NUM_OUT-1:0] ppv_q, ppv_d;
  logic [NUM_IN*NUM_OUT-1:0] alloc_q, alloc_d;
  logic [NUM_IN*NUM_OUT-1:0] unalloc_q, unalloc_d;
  logic [NUM_OUT-1:0]        avail_q, avail_d;
  logic [NUM_OUT-1:0]        avail_out_q, avail_out_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          nfo_q, nfo_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [NUM_IN*NUM_OUT-1:0] masked_ppv;
  logic [NUM_OUT-1:0]        cur_ppv;
  logic [NUM_OUT-1:0]        grants;
  logic [NUM_OUT-1:0]        avail_next;
  logic [CNT_W-1:0]          c;
  logic                      cur_mc;

  // Invalid slots carry a zero ppv so they never grant and report no unalloc.
  always_comb begin
    masked_ppv = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      masked_ppv[k*NUM_OUT +: NUM_OUT] = in_valid[k] ? in_ppv[k*NUM_OUT +: NUM_OUT] : '0;
    end
  end

  always_comb begin
    cur_ppv = ppv_q[int'(idx_q)*NUM_OUT +: NUM_OUT];
    cur_mc  = mc_q[idx_q];
    grants  = '0;
    c       = cnt_q;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (cur_ppv[i] && avail_q[i] && (!cur_mc || ({1'b0, c} < LIM))) begin
        grants[i] = 1'b1;
        c         = c + CNT_W'(1);
      end
    end
    avail_next = avail_q & ~grants;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mc_d        = mc_q;
    ppv_d       = ppv_q;
    alloc_d     = alloc_q;
    unalloc_d   = unalloc_q;
    avail_d     = avail_q;
    avail_out_d = avail_out_q;
    cnt_d       = cnt_q;
    nfo_d       = nfo_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          mc_d      = in_mc;
          ppv_d     = masked_ppv;
          avail_d   = '1;
          cnt_d     = '0;
          idx_d     = '0;
          alloc_d   = '0;
          unalloc_d = masked_ppv;
          busy_d    = 1'b1;
          state_d   = S_ALLOC;
        end
      end
      S_ALLOC: begin
        alloc_d[int'(idx_q)*NUM_OUT +: NUM_OUT]   = grants;
        unalloc_d[int'(idx_q)*NUM_OUT +: NUM_OUT] = cur_ppv & ~grants;
        avail_d = avail_next;
        cnt_d   = c;
        if ((idx_q == LAST_IDX) || (avail_next == '0)) begin
          // Finals are published on entry to DONE so they are valid alongside done.
          avail_out_d = avail_next;
          nfo_d       = c;
          done_d      = 1'b1;
          state_d     = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        avail_out_d = avail_q;
        nfo_d       = cnt_q;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      mc_q        <= '0;
      ppv_q       <= '0;
      alloc_q     <= '0;
      unalloc_q   <= '0;
      avail_q     <= '1;
      avail_out_q <= '1;
      cnt_q       <= '0;
      nfo_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mc_q        <= mc_d;
      ppv_q       <= ppv_d;
      alloc_q     <= alloc_d;
      unalloc_q   <= unalloc_d;
      avail_q     <= avail_d;
      avail_out_q <= avail_out_d;
      cnt_q       <= cnt_d;
      nfo_q       <= nfo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign alloc_vec    = alloc_q;
  assign unalloc_vec  = unalloc_q;
  assign avail_out    = avail_out_q;
  assign num_flit_out = nfo_q;

endmodule

// File: tb/tb_mc_port_alloc_seq.sv
// Bench for mc_port_alloc_seq: directed and random batches on two instances
// (replica limit 3 and 4) checked against a slot-by-slot allocation model.
module tb_mc_port_alloc_seq;

  localparam int NI = 4;
  localparam int NO = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic [NI-1:0]    in_valid = '0;
  logic [NI-1:0]    in_mc = '0;
  logic [NI*NO-1:0] in_ppv = '0;

  logic busy_a, done_a, busy_b, done_b;
  logic [NI*NO-1:0] alloc_a, unalloc_a, alloc_b, unalloc_b;
  logic [NO-1:0]    avail_a, avail_b;
  logic [CW-1:0]    nfo_a, nfo_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mc_port_alloc_seq #(.NUM_IN(NI), .NUM_OUT(NO), .CNT_W(CW), .REPLICA_LIMIT(3)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid), .in_mc(in_mc),
    .in_ppv(in_ppv), .busy(busy_a), .done(done_a), .alloc_vec(alloc_a),
    .unalloc_vec(unalloc_a), .avail_out(avail_a), .num_flit_out(nfo_a));

  mc_port_alloc_seq #(.NUM_IN(NI), .NUM_OUT(NO), .CNT_W(CW), .REPLICA_LIMIT(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid), .in_mc(in_mc),
    .in_ppv(in_ppv), .busy(busy_b), .done(done_b), .alloc_vec(alloc_b),
    .unalloc_vec(unalloc_b), .avail_out(avail_b), .num_flit_out(nfo_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each slot in priority order takes every productive free port,
  // multicast slots only while fewer than lim replicas exist; stop when ports run out.
  task automatic model(input logic [NI-1:0] v, input logic [NI-1:0] mc,
                       input logic [NI*NO-1:0] ppv, input int lim,
                       output logic [NI*NO-1:0] al, output logic [NI*NO-1:0] un,
                       output logic [NO-1:0] av, output int cnt, output int nproc);
    bit stop;
    av = '1; cnt = 0; al = '0; un = '0; nproc = 0; stop = 0;
    for (int k = 0; k < NI; k++)
      for (int i = 0; i < NO; i++)
        un[k*NO+i] = v[k] & ppv[k*NO+i];
    for (int k = 0; k < NI; k++) begin
      if (!stop) begin
        nproc = k + 1;
        for (int i = 0; i < NO; i++) begin
          if (v[k] && ppv[k*NO+i] && av[i] && (!mc[k] || cnt < lim)) begin
            al[k*NO+i] = 1'b1;
            un[k*NO+i] = 1'b0;
            av[i] = 1'b0;
            cnt++;
          end
        end
        if (av == '0) stop = 1;
      end
    end
  endtask

  task automatic get_outs(input int sel, output logic b, output logic d,
                          output logic [NI*NO-1:0] al, output logic [NI*NO-1:0] un,
                          output logic [NO-1:0] av, output logic [CW-1:0] nf);
    if (sel == 0) begin
      b = busy_a; d = done_a; al = alloc_a; un = unalloc_a; av = avail_a; nf = nfo_a;
    end else begin
      b = busy_b; d = done_b; al = alloc_b; un = unalloc_b; av = avail_b; nf = nfo_b;
    end
  endtask

  task automatic set_start(input int sel, input logic val);
    if (sel == 0) start_a = val;
    else start_b = val;
  endtask

  // Runs one batch on a fixed cycle schedule derived from the model, so a DUT
  // that finishes early or late shows up as busy/done mismatches rather than a hang.
  task automatic run_batch(input int sel, input string tag, input logic [NI-1:0] v,
                           input logic [NI-1:0] mc, input logic [NI*NO-1:0] ppv,
                           input bit poke);
    logic [NI*NO-1:0] e_al, e_un, al, un;
    logic [NO-1:0] e_av, av;
    int e_cnt, e_np;
    logic b, d;
    logic [CW-1:0] nf;
    model(v, mc, ppv, (sel == 0) ? 3 : 4, e_al, e_un, e_av, e_cnt, e_np);
    @(negedge clk);
    in_valid = v; in_mc = mc; in_ppv = ppv;
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    for (int j = 0; j < e_np; j++) begin
      get_outs(sel, b, d, al, un, av, nf);
      chk({tag, " busy_alloc"}, 32'(b), 32'd1);
      chk({tag, " done_early"}, 32'(d), 32'd0);
      if (poke && j == 0) begin
        set_start(sel, 1'b1);
        in_valid = 4'(($urandom_range(0, 15)));
        in_mc = 4'(($urandom_range(0, 15)));
        in_ppv = 16'(($urandom_range(0, 65535)));
      end
      @(negedge clk);
      set_start(sel, 1'b0);
    end
    get_outs(sel, b, d, al, un, av, nf);
    chk({tag, " done_pulse"}, 32'(d), 32'd1);
    chk({tag, " busy_done"}, 32'(b), 32'd1);
    chk({tag, " alloc"}, 32'(al), 32'(e_al));
    chk({tag, " unalloc"}, 32'(un), 32'(e_un));
    if (poke) set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    get_outs(sel, b, d, al, un, av, nf);
    chk({tag, " done_low"}, 32'(d), 32'd0);
    chk({tag, " busy_idle"}, 32'(b), 32'd0);
    chk({tag, " alloc_hold"}, 32'(al), 32'(e_al));
    chk({tag, " unalloc_hold"}, 32'(un), 32'(e_un));
    chk({tag, " avail_out"}, 32'(av), 32'(e_av));
    chk({tag, " num_flit_out"}, 32'(nf), 32'(e_cnt));
    if (poke) begin
      @(negedge clk);
      get_outs(sel, b, d, al, un, av, nf);
      chk({tag, " no_second_batch"}, 32'(b), 32'd0);
      chk({tag, " no_second_done"}, 32'(d), 32'd0);
    end
  endtask

  task automatic check_reset_state(input int sel, input string tag);
    logic b, d;
    logic [NI*NO-1:0] al, un;
    logic [NO-1:0] av;
    logic [CW-1:0] nf;
    get_outs(sel, b, d, al, un, av, nf);
    chk({tag, " busy"}, 32'(b), 32'd0);
    chk({tag, " done"}, 32'(d), 32'd0);
    chk({tag, " alloc"}, 32'(al), 32'd0);
    chk({tag, " unalloc"}, 32'(un), 32'd0);
    chk({tag, " avail_out"}, 32'(av), 32'hF);
    chk({tag, " num_flit_out"}, 32'(nf), 32'd0);
  endtask

  initial begin
    logic [NI*NO-1:0] m_al, m_un;
    logic [NO-1:0] m_av;
    int m_cnt, m_np;

    // Pin the model against hand-worked cases.
    model(4'b1111, 4'b0000, 16'b1000_0100_0010_0001, 3, m_al, m_un, m_av, m_cnt, m_np);
    chk("model_uni alloc", 32'(m_al), 32'h8421);
    chk("model_uni nproc", 32'(m_np), 32'd4);
    chk("model_uni cnt", 32'(m_cnt), 32'd4);
    model(4'b0011, 4'b0010, 16'b0000_0000_1110_0001, 3, m_al, m_un, m_av, m_cnt, m_np);
    chk("model_rep alloc", 32'(m_al), 32'h0061);
    chk("model_rep unalloc", 32'(m_un), 32'h0080);
    chk("model_rep avail", 32'(m_av), 32'h8);
    model(4'b1111, 4'b0001, 16'b1000_0101_0011_1111, 4, m_al, m_un, m_av, m_cnt, m_np);
    chk("model_early nproc", 32'(m_np), 32'd1);
    chk("model_early unalloc", 32'(m_un), 32'h8530);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state(0, "reset_a");
    check_reset_state(1, "reset_b");

    run_batch(0, "unicast", 4'b1111, 4'b0000, 16'b1000_0100_0010_0001, 0);
    run_batch(0, "replica", 4'b0011, 4'b0010, 16'b0000_0000_1110_0001, 0);
    run_batch(0, "contention", 4'b0011, 4'b0000, 16'b0000_0000_0011_0011, 0);
    run_batch(1, "early_exit", 4'b1111, 4'b0001, 16'b1000_0101_0011_1111, 0);
    run_batch(0, "ignored_start", 4'b0111, 4'b0101, 16'b0000_1100_0110_0011, 1);

    // Reset while slot 1 is being processed, after a batch left avail_out at 0000.
    run_batch(0, "pre_reset", 4'b1111, 4'b0000, 16'b1000_0100_0010_0001, 0);
    @(negedge clk);
    in_valid = 4'b1111; in_mc = 4'b0000; in_ppv = 16'b0001_0010_0100_1000;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_state(0, "midreset");
    repeat (5) begin
      @(negedge clk);
      chk("midreset no_resume busy", 32'(busy_a), 32'd0);
      chk("midreset no_resume done", 32'(done_a), 32'd0);
    end

    for (int t = 0; t < 60; t++) begin
      run_batch(t % 2, "random",
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                16'($urandom_range(0, 65535)), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
